// File: rtl/ccc_lock_supervisor.sv
// PLL power-up/recovery sequencer: drives CCC powerdown/reset, qualifies LOCK, gates fabric reset.
// Latency: outputs registered, one edge per state change. Backpressure: none. Option macro: CCC_SUP_LOSS_COUNTER_EN.
module ccc_lock_supervisor #(
    parameter int ARST_CYCLES         = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic       REARM,
    input  logic       LOCK,
    output logic       PLL_POWERDOWN_N,
    output logic       PLL_ARST_N,
    output logic       FABRIC_RESET_N,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);
    localparam int MAXP0 = (ARST_CYCLES > LOCK_TIMEOUT_CYCLES) ? ARST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAXP  = (MAXP0 > LOCK_STABLE_CYCLES) ? MAXP0 : LOCK_STABLE_CYCLES;
    localparam int CW    = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] ARST_LAST   = CW'(ARST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_ARST, S_WAIT_LOCK, S_STABILIZE, S_RUN, S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          lock_meta_q, lock_s_q;
    logic          pd_n_q, pd_n_d, arst_n_q, arst_n_d, frst_n_q, frst_n_d;
    logic          ready_q, ready_d, fault_q, fault_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= LOCK;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (!ENABLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      state_d = S_ARST;
                S_ARST:      if (cnt_q == ARST_LAST) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    // Lock beats a coincident timeout.
                    if (lock_s_q) begin
                        state_d = S_STABILIZE;
                    end else if (cnt_q == TO_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            state_d = S_ARST;
                            retry_d = retry_q + 4'd1;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                end
                S_STABILIZE: begin
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = 4'd0;
                    end
                end
                S_RUN:       if (!lock_s_q) state_d = S_ARST;
                S_FAULT: begin
                    if (REARM) begin
                        state_d = S_IDLE;
                        retry_d = 4'd0;
                    end
                end
                default:     state_d = S_IDLE;
            endcase
        end

        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_FAULT))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;

        // Outputs are decoded from the next state so they change on the entry edge.
        pd_n_d   = 1'b1;
        arst_n_d = 1'b1;
        frst_n_d = 1'b0;
        ready_d  = 1'b0;
        fault_d  = 1'b0;
        case (state_d)
            S_IDLE:  begin pd_n_d = 1'b0; arst_n_d = 1'b0; end
            S_ARST:  arst_n_d = 1'b0;
            S_RUN:   begin frst_n_d = 1'b1; ready_d = 1'b1; end
            S_FAULT: begin arst_n_d = 1'b0; fault_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            retry_q  <= 4'd0;
            pd_n_q   <= 1'b0;
            arst_n_q <= 1'b0;
            frst_n_q <= 1'b0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            pd_n_q   <= pd_n_d;
            arst_n_q <= arst_n_d;
            frst_n_q <= frst_n_d;
            ready_q  <= ready_d;
            fault_q  <= fault_d;
        end
    end

`ifdef CCC_SUP_LOSS_COUNTER_EN
    logic [7:0] loss_q;
    logic       loss_inc;

    assign loss_inc = ENABLE && (state_q == S_RUN) && !lock_s_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            loss_q <= 8'd0;
        else if (loss_inc && (loss_q != 8'hFF))
            loss_q <= loss_q + 8'd1;
    end

    assign LOSS_CNT = loss_q;
`else
    assign LOSS_CNT = 8'd0;
`endif

    assign PLL_POWERDOWN_N = pd_n_q;
    assign PLL_ARST_N      = arst_n_q;
    assign FABRIC_RESET_N  = frst_n_q;
    assign READY           = ready_q;
    assign FAULT           = fault_q;
    assign RETRY_CNT       = retry_q;
endmodule

// File: tb/tb_ccc_lock_supervisor.sv
// Directed bench for ccc_lock_supervisor with short timing parameters.
module tb_ccc_lock_supervisor;
`ifdef CCC_SUP_LOSS_COUNTER_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       ENABLE = 1'b0;
    logic       REARM = 1'b0;
    logic       LOCK = 1'b0;
    logic       PLL_POWERDOWN_N, PLL_ARST_N, FABRIC_RESET_N, READY, FAULT;
    logic [3:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;

    int n_chk  = 0;
    int n_pass = 0;

    ccc_lock_supervisor #(
        .ARST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32), .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .REARM(REARM), .LOCK(LOCK),
        .PLL_POWERDOWN_N(PLL_POWERDOWN_N), .PLL_ARST_N(PLL_ARST_N),
        .FABRIC_RESET_N(FABRIC_RESET_N), .READY(READY), .FAULT(FAULT),
        .RETRY_CNT(RETRY_CNT), .LOSS_CNT(LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return READY;
            1:       return PLL_ARST_N;
            2:       return FAULT;
            default: return FABRIC_RESET_N;
        endcase
    endfunction

    // Ticks until the selected output equals val; n = edges taken (limit on expiry).
    task automatic wait_sig(input int which, input logic val, input int limit, output int n);
        n = 0;
        while (n < limit && sel(which) != val) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pd"},    PLL_POWERDOWN_N, 0);
        chk({tag, "_arst"},  PLL_ARST_N, 0);
        chk({tag, "_frst"},  FABRIC_RESET_N, 0);
        chk({tag, "_ready"}, READY, 0);
        chk({tag, "_fault"}, FAULT, 0);
        chk({tag, "_retry"}, RETRY_CNT, 0);
        chk({tag, "_loss"},  LOSS_CNT, 0);
    endtask

    initial begin
        int n;
        int sat_err;

        repeat (2) tick();
        chk_reset_vals("rst");
        RESET_N = 1'b1;
        tick();
        chk("idle_pd", PLL_POWERDOWN_N, 0);

        // Nominal bring-up
        ENABLE = 1'b1;
        tick();
        chk("arst_entry_pd", PLL_POWERDOWN_N, 1);
        chk("arst_entry_arst", PLL_ARST_N, 0);
        wait_sig(1, 1'b1, 20, n);
        chk("arst_low_cycles", n, 4);
        repeat (10) tick();
        chk("wait_lock_ready", READY, 0);
        LOCK = 1'b1;
        wait_sig(0, 1'b1, 50, n);
        chk("lock_to_ready", n, 11);
        chk("run_frst", FABRIC_RESET_N, 1);
        chk("run_retry", RETRY_CNT, 0);

        // Loss in RUN, then relock
        LOCK = 1'b0;
        wait_sig(3, 1'b0, 10, n);
        chk("loss_to_frst", n, 3);
        chk("loss_arst", PLL_ARST_N, 0);
        chk("loss_ready", READY, 0);
        chk("loss_cnt1", LOSS_CNT, LOSS_EN);
        LOCK = 1'b1;
        wait_sig(0, 1'b1, 50, n);
        chk("relock_ready", n, 13);
        chk("relock_retry", RETRY_CNT, 0);

        // Disable, re-enable, glitchy lock
        LOCK = 1'b0;
        ENABLE = 1'b0;
        tick();
        chk("disable_pd", PLL_POWERDOWN_N, 0);
        chk("disable_loss", LOSS_CNT, LOSS_EN);
        ENABLE = 1'b1;
        tick();
        wait_sig(1, 1'b1, 20, n);
        chk("glitch_arst_cycles", n, 4);
        LOCK = 1'b1;
        repeat (5) tick();
        LOCK = 1'b0;
        tick();
        LOCK = 1'b1;
        wait_sig(0, 1'b1, 50, n);
        chk("glitch_to_ready", n + 6, 17);

        // Asynchronous reset mid-RUN
        #3 RESET_N = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        RESET_N = 1'b1;

        // ENABLE=0 during STABILIZE
        tick();
        chk("re_arst", PLL_ARST_N, 0);
        wait_sig(1, 1'b1, 20, n);
        repeat (3) tick();
        chk("stab_ready", READY, 0);
        chk("stab_arst", PLL_ARST_N, 1);
        ENABLE = 1'b0;
        tick();
        chk("abort_pd", PLL_POWERDOWN_N, 0);
        chk("abort_arst", PLL_ARST_N, 0);
        ENABLE = 1'b1;
        LOCK = 1'b0;
        tick();
        chk("abort_reenter_pd", PLL_POWERDOWN_N, 1);

        // Timeouts to FAULT
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("to_retry%0d", k), RETRY_CNT, k);
            chk($sformatf("to_arst_low%0d", k), PLL_ARST_N, 0);
            wait_sig(1, 1'b1, 20, n);
            chk($sformatf("to_arst_cycles%0d", k), n, 4);
            wait_sig(1, 1'b0, 50, n);
            chk($sformatf("to_wait_cycles%0d", k), n, 32);
        end
        chk("fault_flag", FAULT, 1);
        chk("fault_pd", PLL_POWERDOWN_N, 1);
        chk("fault_retry", RETRY_CNT, 2);
        repeat (3) tick();
        chk("fault_hold", FAULT, 1);
        REARM = 1'b1;
        tick();
        REARM = 1'b0;
        chk("rearm_fault", FAULT, 0);
        chk("rearm_pd", PLL_POWERDOWN_N, 0);
        chk("rearm_retry", RETRY_CNT, 0);
        tick();
        chk("rearm_arst_pd", PLL_POWERDOWN_N, 1);

        // LOSS_CNT saturation
        LOCK = 1'b1;
        wait_sig(0, 1'b1, 60, n);
        chk("sat_first_run", READY, 1);
        sat_err = 0;
        for (int i = 0; i < 256; i++) begin
            LOCK = 1'b0;
            wait_sig(3, 1'b0, 10, n);
            if (n >= 10) sat_err++;
            LOCK = 1'b1;
            wait_sig(0, 1'b1, 40, n);
            if (n >= 40) sat_err++;
        end
        chk("sat_loop_timeouts", sat_err, 0);
        chk("sat_loss_cnt", LOSS_CNT, 255 * LOSS_EN);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
